encode_li_seq: RTL and testbench
================================

Name: encode_li_seq

Overview:
- Encoder counterpart of the U-type decode path. Expands a "load 32-bit constant" request (li / la pseudo-instruction) into a legal RV32I instruction stream.
- The stream is LUI (or AUIPC) followed by ADDI. Words are emitted over a valid/ready handshake.
- Sits between the test-program generator / boot-ROM builder and the instruction memory writer. Its output must round-trip through the U-type and I-type decoders.

Parameters:
- IDLE_INST, 32'h0000_0013, value driven on out_inst whenever out_valid=0 (canonical NOP).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_rd  input  5  destination register
- req_value  input  32  constant (pcrel=0) or PC offset (pcrel=1)
- req_pcrel  input  1  0: LUI-based, 1: AUIPC-based
- out_valid  output  1  out_inst holds a valid instruction word
- out_ready  input  1  consumer accepts out_inst
- out_inst  output  32  encoded instruction
- out_last  output  1  out_inst is the final word of the current expansion
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) forces the following, regardless of activity; any in-flight expansion is discarded, with no partial word completed after release:
  - state=IDLE
  - out_valid=0, out_last=0, out_inst=IDLE_INST
  - busy=0
  - latched request cleared
- States and transitions:
  - IDLE: req_ready=1 only here; a request is accepted when req_valid && req_ready.
  - On accept: latch rd, hi, lo, pcrel; next state EMIT_HI.
  - hi = (req_value + 32'h800)[31:12], computed modulo 2^32 so wrap-around is ignored. lo = req_value[11:0].
  - EMIT_HI: out_inst = {hi, rd, opcode}, opcode 7'b0110111 (LUI) or 7'b0010111 (AUIPC); out_last=0. On out_valid && out_ready, go to EMIT_LO.
  - EMIT_LO: out_inst = {lo, rd, 3'b000, rd, 7'b0010011} (ADDI rd,rd,lo); out_last=1. On handshake, go to IDLE.
- Latency and throughput:
  - out_valid rises the cycle after acceptance.
  - Minimum 3 cycles per request, since req_ready is low in EMIT_HI and EMIT_LO and returns high the cycle after the final handshake.
- All outputs are registered; no combinational path from req_* or out_ready to out_inst/out_valid.
- Backpressure: while out_valid && !out_ready, out_inst and out_last are held stable.
- rd=0 is encoded normally; no special-casing.
- lo=0 still emits ADDI rd,rd,0 unless the optional feature applies.
- Invariant: sign-extended lo + (hi<<12) == req_value mod 2^32.

Optional Feature:
- Macro: LI_SHORT_EN.
- Defined: if req_pcrel=0 and req_value[31:11] are all equal (fits a signed 12-bit immediate), skip EMIT_HI. Go directly to EMIT_LO, emitting ADDI rd,x0,lo ({lo,5'd0,3'b000,rd,7'b0010011}) with out_last=1. Single-word latency is 1 cycle.
- Undefined: always emit two words. pcrel=1 requests are never shortened in either build.

Test Plan:
- rd=5, value=32'h12345678, pcrel=0 -> 32'h123452B7 (last=0), then 32'h67828293 (last=1).
- Rounding: rd=1, value=32'h00000FFF -> 32'h000010B7, 32'hFFF08093.
- AUIPC with negative lo: rd=10, value=32'h00001800, pcrel=1 -> 32'h00002517, 32'h80050513. Wrap case rd=3, value=32'hFFFFF800 -> 32'h000001B7, 32'h80018193.
- Backpressure: hold out_ready=0 for 3 cycles in EMIT_HI -> out_inst/out_valid stable, req_ready=0 throughout, req_valid ignored; release -> normal sequence.
- Reset mid-op: assert rst_n=0 during EMIT_LO -> immediately out_valid=0, out_inst=32'h00000013, busy=0. After release, req_ready=1 and the next request encodes cleanly.
- rd=2, value=32'hFFFFFFFF, pcrel=0:
  - LI_SHORT_EN defined -> single 32'hFFF00113, last=1.
  - Undefined -> 32'h00000137, then 32'hFFF10113.

Source files
------------

// File: rtl/encode_li_seq.sv
// Expands a "load 32-bit constant" request into LUI/AUIPC + ADDI and streams the
// words over valid/ready. Defining LI_SHORT_EN lets small absolute constants go out
// as a single ADDI rd,x0,lo.
module encode_li_seq #(
    parameter logic [31:0] IDLE_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_value,
    input  logic        req_pcrel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        busy
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [19:0] hi;
        logic [11:0] lo;
        logic        pcrel;
        logic        short_form;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic        out_valid_q;
    logic        out_last_q;
    logic [31:0] out_inst_q;

    logic        accept;
    logic        out_fire;
    logic        fits_imm12;
    logic [19:0] hi_calc;

    // Word presented in a given state for a given latched request.
    function automatic logic [31:0] encode_word(input state_t st, input req_t r);
        logic [31:0] w;
        w = IDLE_INST;
        case (st)
            EMIT_HI: w = {r.hi, r.rd, (r.pcrel ? OPC_AUIPC : OPC_LUI)};
            EMIT_LO: w = {r.lo, (r.short_form ? 5'd0 : r.rd), 3'b000, r.rd, OPC_OPIMM};
            default: w = IDLE_INST;
        endcase
        return w;
    endfunction

    assign accept   = req_valid && (state_q == IDLE);
    assign out_fire = out_valid_q && out_ready;

    // (v + 0x800) >> 12 equals v[31:12] + v[11]; the 20-bit add wraps for free.
    assign hi_calc = req_value[31:12] + {19'd0, req_value[11]};

`ifdef LI_SHORT_EN
    assign fits_imm12 = !req_pcrel && ((&req_value[31:11]) || !(|req_value[31:11]));
`else
    assign fits_imm12 = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.rd         = req_rd;
                    req_d.hi         = hi_calc;
                    req_d.lo         = req_value[11:0];
                    req_d.pcrel      = req_pcrel;
                    req_d.short_form = fits_imm12;
                    state_d          = fits_imm12 ? EMIT_LO : EMIT_HI;
                end
            end
            EMIT_HI: begin
                if (out_fire) state_d = EMIT_LO;
            end
            EMIT_LO: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are flopped from next-state values so they change only on the clock
    // and stay frozen while the consumer stalls.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_inst_q  <= IDLE_INST;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            out_valid_q <= (state_d != IDLE);
            out_last_q  <= (state_d == EMIT_LO);
            out_inst_q  <= encode_word(state_d, req_d);
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_encode_li_seq.sv
// Directed bench for encode_li_seq: hand-computed encodings, backpressure,
// mid-expansion reset and the LI_SHORT_EN build variant.
module tb_encode_li_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_value;
    logic        req_pcrel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    encode_li_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_value (req_value),
        .req_pcrel (req_pcrel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, then confirm out_valid
    // rises the cycle after the accepting edge.
    task automatic send(input string tag, input logic [4:0] rd, input logic [31:0] val,
                        input logic pcrel);
        int waited;
        req_valid = 1'b1;
        req_rd    = rd;
        req_value = val;
        req_pcrel = pcrel;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    endtask

    // With out_ready high the word present now is consumed at the next edge.
    task automatic take(input string tag, input logic [31:0] exp_inst, input logic exp_last);
        out_ready = 1'b1;
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, exp_last});
        tick();
    endtask

    task automatic finish_idle(input string tag);
        check({tag, "_idle"}, {30'd0, req_ready, busy}, 32'd2);
        check({tag, "_nop"}, out_inst, 32'h0000_0013);
    endtask

    initial begin
        logic [31:0] held;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rd    = '0;
        req_value = '0;
        req_pcrel = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'h0000_0013);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        send("basic", 5'd5, 32'h1234_5678, 1'b0);
        take("basic_hi", 32'h1234_52B7, 1'b0);
        take("basic_lo", 32'h6782_8293, 1'b1);
        finish_idle("basic");

        send("round", 5'd1, 32'h0000_0FFF, 1'b0);
        take("round_hi", 32'h0000_10B7, 1'b0);
        take("round_lo", 32'hFFF0_8093, 1'b1);
        finish_idle("round");

        send("auipc", 5'd10, 32'h0000_1800, 1'b1);
        take("auipc_hi", 32'h0000_2517, 1'b0);
        take("auipc_lo", 32'h8005_0513, 1'b1);
        finish_idle("auipc");

        send("wrap", 5'd3, 32'hFFFF_F800, 1'b0);
`ifdef LI_SHORT_EN
        take("wrap_short", 32'h8000_0193, 1'b1);
`else
        take("wrap_hi", 32'h0000_01B7, 1'b0);
        take("wrap_lo", 32'h8001_8193, 1'b1);
`endif
        finish_idle("wrap");

        send("neg1", 5'd2, 32'hFFFF_FFFF, 1'b0);
`ifdef LI_SHORT_EN
        take("neg1_short", 32'hFFF0_0113, 1'b1);
`else
        take("neg1_hi", 32'h0000_0137, 1'b0);
        take("neg1_lo", 32'hFFF1_0113, 1'b1);
`endif
        finish_idle("neg1");

        send("small", 5'd7, 32'h0000_0123, 1'b0);
`ifdef LI_SHORT_EN
        take("small_short", 32'h1230_0393, 1'b1);
`else
        take("small_hi", 32'h0000_03B7, 1'b0);
        take("small_lo", 32'h1233_8393, 1'b1);
`endif
        finish_idle("small");

        // AUIPC is never shortened, even when the offset fits 12 bits.
        send("pc_small", 5'd0, 32'h0000_0004, 1'b1);
        take("pc_small_hi", 32'h0000_0017, 1'b0);
        take("pc_small_lo", 32'h0040_0013, 1'b1);
        finish_idle("pc_small");

        // Backpressure in EMIT_HI with a competing request that must be ignored.
        out_ready = 1'b0;
        send("bp", 5'd5, 32'h1234_5678, 1'b0);
        held      = out_inst;
        check("bp_held_hi", held, 32'h1234_52B7);
        req_valid = 1'b1;
        req_rd    = 5'd9;
        req_value = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            check("bp_inst", out_inst, held);
            check("bp_vld", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            check("bp_last", {31'd0, out_last}, 32'd0);
            tick();
        end
        req_valid = 1'b0;
        take("bp_hi", 32'h1234_52B7, 1'b0);
        take("bp_lo", 32'h6782_8293, 1'b1);
        finish_idle("bp");

        // Asynchronous reset while the ADDI word is waiting.
        send("mid", 5'd1, 32'h0000_0FFF, 1'b0);
        take("mid_hi", 32'h0000_10B7, 1'b0);
        out_ready = 1'b0;
        check("mid_in_lo", {31'd0, out_last}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check("mid_rst_inst", out_inst, 32'h0000_0013);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("mid_post_vld", {31'd0, out_valid}, 32'd0);
        check("mid_post_ready", {31'd0, req_ready}, 32'd1);
        out_ready = 1'b1;
        send("after", 5'd10, 32'h0000_1800, 1'b1);
        take("after_hi", 32'h0000_2517, 1'b0);
        take("after_lo", 32'h8005_0513, 1'b1);
        finish_idle("after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
